decode_scoreboard: RTL and testbench

DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

---
 rtl/decode_scoreboard_pkg.sv | 18 +
 rtl/decode_fwd_lookup.sv | 41 ++++
 rtl/decode_scoreboard.sv | 82 ++++++++
 tb/tb_decode_scoreboard.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/decode_scoreboard_pkg.sv
// Shared definitions for the decode scoreboard: the per-stage entry record,
// the forward-select encoding for "use register file" and parameter defaults.
package decode_scoreboard_pkg;

  localparam int DEPTH_DEF    = 3;
  localparam int LOAD_LAT_DEF = 1;

  // Select value 0 means "no forward, read the register file";
  // k+1 means "forward from entry k".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] waddr;
    logic       is_load;
  } sb_entry_t;

endpackage

// File: rtl/decode_fwd_lookup.sv
// Operand lookup against the in-flight destination entries.
// Ports:
//   addr      source register of the operand
//   used      operand is actually read this cycle
//   entries   in-flight entries, index 0 = youngest
//   sel       0 = register file, k+1 = forward from entry k (ready match only)
//   not_ready operand is used and its youngest producer cannot forward yet
module decode_fwd_lookup
  import decode_scoreboard_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int SELW     = $clog2(DEPTH + 1)
) (
  input  logic [4:0]             addr,
  input  logic                   used,
  input  sb_entry_t [DEPTH-1:0]  entries,
  output logic [SELW-1:0]        sel,
  output logic                   not_ready
);

  logic found;

  // Scan young to old; the first hit shadows every older one, so an older
  // ready producer is never chosen over a younger not-ready one.
  always_comb begin
    sel       = SELW'(FWD_RF);
    not_ready = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && entries[k].valid && (entries[k].waddr == addr) && (addr != 5'd0)) begin
        found = 1'b1;
        if (entries[k].is_load && (k < LOAD_LAT))
          not_ready = used;
        else
          sel = SELW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage scoreboard: tracks destinations of the last DEPTH issued
// instructions, produces per-operand forward selects and a load-use stall.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   issue_valid/we/waddr/is_load  instruction in decode and its destination
//   rs_addr/rt_addr, rs_used/rt_used  source operands
//   flush                    kill the instruction in decode
//   stall                    hold fetch/decode, insert a bubble
//   fwd_rs_sel/fwd_rt_sel    0 = register file, k+1 = forward from entry k
//   stall_count              saturating count of stall cycles
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int SELW     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [4:0]      issue_waddr,
  input  logic            issue_is_load,
  input  logic [4:0]      rs_addr,
  input  logic [4:0]      rt_addr,
  input  logic            rs_used,
  input  logic            rt_used,
  input  logic            flush,
  output logic            stall,
  output logic [SELW-1:0] fwd_rs_sel,
  output logic [SELW-1:0] fwd_rt_sel,
  output logic [31:0]     stall_count
);

  sb_entry_t [DEPTH-1:0] entries_q;
  sb_entry_t             ent_new;
  logic                  rs_nr, rt_nr;
  logic [31:0]           cnt_q;

  decode_fwd_lookup #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SELW(SELW)) u_rs (
    .addr      (rs_addr),
    .used      (rs_used),
    .entries   (entries_q),
    .sel       (fwd_rs_sel),
    .not_ready (rs_nr)
  );

  decode_fwd_lookup #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SELW(SELW)) u_rt (
    .addr      (rt_addr),
    .used      (rt_used),
    .entries   (entries_q),
    .sel       (fwd_rt_sel),
    .not_ready (rt_nr)
  );

  // Flush overrides stall: a killed instruction has no hazard.
  assign stall = issue_valid & ~flush & (rs_nr | rt_nr);

  // Stalled, flushed, non-writing and $0-writing instructions all enter as
  // bubbles so nothing can ever match against them.
  always_comb begin
    ent_new.valid   = issue_valid & issue_we & ~stall & ~flush & (issue_waddr != 5'd0);
    ent_new.waddr   = issue_waddr;
    ent_new.is_load = issue_is_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
      cnt_q     <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++)
        entries_q[k] <= entries_q[k-1];
      entries_q[0] <= ent_new;
      if (stall && (cnt_q != 32'hFFFF_FFFF))
        cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
module tb_decode_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_we, issue_is_load, flush;
  logic [4:0] issue_waddr, rs_addr, rt_addr;
  logic       rs_used, rt_used;

  logic        stall_a, stall_b;
  logic [1:0]  rs_sel_a, rt_sel_a;
  logic [2:0]  rs_sel_b, rt_sel_b;
  logic [31:0] cnt_a, cnt_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // a: DEPTH=3, LOAD_LAT=1 ; b: DEPTH=4, LOAD_LAT=2
  decode_scoreboard dut_a (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_waddr(issue_waddr), .issue_is_load(issue_is_load),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .flush(flush), .stall(stall_a), .fwd_rs_sel(rs_sel_a), .fwd_rt_sel(rt_sel_a),
    .stall_count(cnt_a)
  );

  decode_scoreboard #(.DEPTH(4), .LOAD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_waddr(issue_waddr), .issue_is_load(issue_is_load),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .flush(flush), .stall(stall_b), .fwd_rs_sel(rs_sel_b), .fwd_rt_sel(rt_sel_b),
    .stall_count(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_we = 0; issue_waddr = 0; issue_is_load = 0;
    rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0; flush = 0;
  endtask

  task automatic issue(input logic we, input logic [4:0] wa, input logic ld,
                       input logic [4:0] rs, input logic ru,
                       input logic [4:0] rt, input logic tu);
    issue_valid = 1; issue_we = we; issue_waddr = wa; issue_is_load = ld;
    rs_addr = rs; rs_used = ru; rt_addr = rt; rt_used = tu; flush = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    check("reset_stall", {31'd0, stall_a}, 32'd0);
    check("reset_rs_sel", {30'd0, rs_sel_a}, 32'd0);
    check("reset_rt_sel", {30'd0, rt_sel_a}, 32'd0);
    check("reset_count", cnt_a, 32'd0);

    // lw $8 ; add $10,$8,$0  (LOAD_LAT=1)
    issue(1, 5'd8, 1, 5'd0, 0, 5'd0, 0);
    #1 check("lw8_nostall", {31'd0, stall_a}, 32'd0);
    tick();
    issue(1, 5'd10, 0, 5'd8, 1, 5'd0, 1);
    #1 check("lduse_stall", {31'd0, stall_a}, 32'd1);
    check("lduse_sel_during", {30'd0, rs_sel_a}, 32'd0);
    tick();
    check("lduse_release", {31'd0, stall_a}, 32'd0);
    check("lduse_sel", {30'd0, rs_sel_a}, 32'd2);
    check("lduse_count", cnt_a, 32'd1);
    tick();
    idle(); tick(); tick(); tick();

    // addu $9 ; reader of $9,$9
    issue(1, 5'd9, 0, 5'd0, 0, 5'd0, 0);
    tick();
    issue(0, 5'd0, 0, 5'd9, 1, 5'd9, 1);
    #1 check("alu_stall", {31'd0, stall_a}, 32'd0);
    check("alu_rs_sel", {30'd0, rs_sel_a}, 32'd1);
    check("alu_rt_sel", {30'd0, rt_sel_a}, 32'd1);
    tick(); idle(); tick(); tick(); tick();

    // two writes to $5, reader picks the youngest
    issue(1, 5'd5, 0, 5'd0, 0, 5'd0, 0); tick();
    issue(1, 5'd5, 0, 5'd0, 0, 5'd0, 0); tick();
    issue(0, 5'd0, 0, 5'd5, 1, 5'd5, 0);
    #1 check("young_rs_sel", {30'd0, rs_sel_a}, 32'd1);
    check("young_rt_sel", {30'd0, rt_sel_a}, 32'd1);
    check("young_stall", {31'd0, stall_a}, 32'd0);
    tick(); idle(); tick(); tick(); tick();

    // $0 never matches
    issue(1, 5'd0, 1, 5'd0, 0, 5'd0, 0); tick();
    issue(0, 5'd0, 0, 5'd0, 1, 5'd0, 1);
    #1 check("r0_rs_sel", {30'd0, rs_sel_a}, 32'd0);
    check("r0_stall", {31'd0, stall_a}, 32'd0);
    tick(); idle();

    // LOAD_LAT=2, DEPTH=4: two stall cycles then sel=3
    rst = 1; tick(); rst = 0;
    issue(1, 5'd3, 1, 5'd0, 0, 5'd0, 0); tick();
    issue(0, 5'd0, 0, 5'd3, 1, 5'd0, 0);
    #1 check("ll2_stall1", {31'd0, stall_b}, 32'd1);
    tick();
    check("ll2_stall2", {31'd0, stall_b}, 32'd1);
    check("ll2_a_sel", {30'd0, rs_sel_a}, 32'd2);
    tick();
    check("ll2_release", {31'd0, stall_b}, 32'd0);
    check("ll2_sel", {29'd0, rs_sel_b}, 32'd3);
    check("ll2_count", cnt_b, 32'd2);
    tick(); idle(); tick(); tick(); tick(); tick();

    // flush beats stall and leaves a bubble
    issue(1, 5'd4, 1, 5'd0, 0, 5'd0, 0); tick();
    issue(1, 5'd4, 0, 5'd4, 1, 5'd0, 0); flush = 1;
    #1 check("flush_stall", {31'd0, stall_a}, 32'd0);
    tick();
    issue(0, 5'd0, 0, 5'd4, 1, 5'd0, 0);
    #1 check("flush_bubble_sel", {30'd0, rs_sel_a}, 32'd2);
    check("flush_bubble_stall", {31'd0, stall_a}, 32'd0);
    tick(); idle(); tick(); tick(); tick();

    // reset in the middle of a stall
    issue(1, 5'd4, 1, 5'd0, 0, 5'd0, 0); tick();
    issue(0, 5'd0, 0, 5'd4, 1, 5'd0, 0);
    #1 check("rst_pre_stall", {31'd0, stall_a}, 32'd1);
    rst = 1; tick(); rst = 0;
    #1 check("rst_post_stall", {31'd0, stall_a}, 32'd0);
    check("rst_post_sel", {30'd0, rs_sel_a}, 32'd0);
    check("rst_post_count", cnt_a, 32'd0);
    idle(); tick();

    // saturation: preload near max, then alternating load-use stalls
    force dut_a.cnt_q = 32'hFFFF_FFFE;
    #1 release dut_a.cnt_q;
    #1 check("sat_preload", cnt_a, 32'hFFFF_FFFE);
    for (int i = 0; i < 10; i++) begin
      issue(1, 5'd8, 1, 5'd8, 1, 5'd0, 0);
      tick();
      if (i == 1) check("sat_first", cnt_a, 32'hFFFF_FFFF);
    end
    check("sat_hold", cnt_a, 32'hFFFF_FFFF);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
